// File: rtl/pulse_classifier.sv
// Classifies measured pulse lengths as glitch/short/long and packs accepted
// pulses into symbol words, emitted on a low-gap timeout or a full buffer.
module pulse_classifier #(
    parameter int SHORT_MIN  = 96,
    parameter int LONG_MIN   = 2880,
    parameter int MAX_PULSES = 5,
    parameter int GAP_CYCLES = 12_500_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [14:0]           tick_total,
    output logic                  pulse_short,
    output logic                  pulse_long,
    output logic                  symbol_valid,
    output logic [MAX_PULSES-1:0] symbol_bits,
    output logic [2:0]            symbol_len
);

    // state    | meaning
    // IDLE     | accumulator empty, waiting for a falling edge
    // LOAD     | capture tick_total (counter holds it for this edge only)
    // CLASSIFY | compare captured length against thresholds, update accumulator
    // GAP      | accumulator non-empty, waiting for next pulse or gap timeout
    typedef enum logic [1:0] {IDLE, LOAD, CLASSIFY, GAP} state_t;

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [14:0]   SHORT_TH  = 15'(SHORT_MIN);
    localparam logic [14:0]   LONG_TH   = 15'(LONG_MIN);
    localparam logic [2:0]    LEN_FULL  = 3'(MAX_PULSES);

    state_t                state, state_nxt;
    logic                  start_q;
    logic [GW-1:0]         gap_cnt;
    logic [14:0]           pulse_len, pulse_len_nxt;
    logic [MAX_PULSES-1:0] acc_bits, acc_bits_nxt, new_bits;
    logic [2:0]            acc_len, acc_len_nxt, new_len;
    logic                  short_nxt, long_nxt, valid_nxt, is_long;
    logic [MAX_PULSES-1:0] sym_bits_nxt;
    logic [2:0]            sym_len_nxt;
    logic                  fall;

    assign fall = start_q & ~start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            gap_cnt      <= '0;
            pulse_len    <= '0;
            acc_bits     <= '0;
            acc_len      <= '0;
            pulse_short  <= 1'b0;
            pulse_long   <= 1'b0;
            symbol_valid <= 1'b0;
            symbol_bits  <= '0;
            symbol_len   <= '0;
        end else begin
            state        <= state_nxt;
            start_q      <= start;
            pulse_len    <= pulse_len_nxt;
            acc_bits     <= acc_bits_nxt;
            acc_len      <= acc_len_nxt;
            pulse_short  <= short_nxt;
            pulse_long   <= long_nxt;
            symbol_valid <= valid_nxt;
            symbol_bits  <= sym_bits_nxt;
            symbol_len   <= sym_len_nxt;
            if (start)
                gap_cnt <= '0;
            else if (gap_cnt != GAP_MAX)
                gap_cnt <= gap_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        pulse_len_nxt = pulse_len;
        acc_bits_nxt  = acc_bits;
        acc_len_nxt   = acc_len;
        short_nxt     = 1'b0;
        long_nxt      = 1'b0;
        valid_nxt     = 1'b0;
        sym_bits_nxt  = symbol_bits;
        sym_len_nxt   = symbol_len;
        is_long       = (pulse_len >= LONG_TH);
        new_bits      = (acc_bits << 1) | MAX_PULSES'(is_long);
        new_len       = acc_len + 3'd1;

        case (state)
            IDLE: begin
                if (fall)
                    state_nxt = LOAD;
            end
            LOAD: begin
                pulse_len_nxt = tick_total;
                state_nxt     = CLASSIFY;
            end
            CLASSIFY: begin
                if (pulse_len < SHORT_TH) begin
                    state_nxt = (acc_len == 3'd0) ? IDLE : GAP;
                end else begin
                    short_nxt = ~is_long;
                    long_nxt  = is_long;
                    if (new_len == LEN_FULL) begin
                        valid_nxt    = 1'b1;
                        sym_bits_nxt = new_bits;
                        sym_len_nxt  = new_len;
                        acc_bits_nxt = '0;
                        acc_len_nxt  = '0;
                        state_nxt    = IDLE;
                    end else begin
                        acc_bits_nxt = new_bits;
                        acc_len_nxt  = new_len;
                        state_nxt    = GAP;
                    end
                end
            end
            GAP: begin
                // Timeout lands on the edge where gap_cnt reaches GAP_CYCLES.
                if (fall) begin
                    state_nxt = LOAD;
                end else if (!start && gap_cnt == GAP_LAST) begin
                    valid_nxt    = 1'b1;
                    sym_bits_nxt = acc_bits;
                    sym_len_nxt  = acc_len;
                    acc_bits_nxt = '0;
                    acc_len_nxt  = '0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pulse_classifier.sv
// Scoreboard bench for pulse_classifier: a counter model presents tick_total
// at E1, a reference model queues expected strobes/emits with their cycle.
module tb_pulse_classifier;

    localparam int GAP = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [14:0] tick_total = '0;
    logic        pulse_short, pulse_long, symbol_valid;
    logic [4:0]  symbol_bits;
    logic [2:0]  symbol_len;

    pulse_classifier #(
        .SHORT_MIN(96), .LONG_MIN(2880), .MAX_PULSES(5), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tick_total(tick_total),
        .pulse_short(pulse_short), .pulse_long(pulse_long),
        .symbol_valid(symbol_valid), .symbol_bits(symbol_bits),
        .symbol_len(symbol_len)
    );

    always #20 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       s;
        logic       l;
        logic       v;
        logic [4:0] bits;
        logic [2:0] len;
    } ev_t;

    ev_t  sb[$];
    ev_t  ev;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [4:0] m_bits = '0;
    logic [2:0] m_len = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes are matched in order against the expected queue.
    always @(negedge clk) begin
        if (reset) begin
            if (pulse_short || pulse_long || symbol_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe cyc=%0d got s=%b l=%b v=%b bits=%b len=%0d, required none",
                             cyc, pulse_short, pulse_long, symbol_valid, symbol_bits, symbol_len);
                end else begin
                    ev = sb.pop_front();
                    if (ev.cyc !== cyc || ev.s !== pulse_short || ev.l !== pulse_long ||
                        ev.v !== symbol_valid ||
                        (ev.v && (ev.bits !== symbol_bits || ev.len !== symbol_len))) begin
                        failures++;
                        $display("FAIL strobe_match got cyc=%0d s=%b l=%b v=%b bits=%b len=%0d, required cyc=%0d s=%b l=%b v=%b bits=%b len=%0d",
                                 cyc, pulse_short, pulse_long, symbol_valid, symbol_bits, symbol_len,
                                 ev.cyc, ev.s, ev.l, ev.v, ev.bits, ev.len);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
                checks++;
                failures++;
                ev = sb.pop_front();
                $display("FAIL missed_strobe at cyc=%0d got nothing, required s=%b l=%b v=%b bits=%b len=%0d",
                         ev.cyc, ev.s, ev.l, ev.v, ev.bits, ev.len);
            end
        end
    end

    // Counter model: tick_total valid only between E0 and E1.
    task automatic drive_pulse(input int ticks, output int e0);
        @(negedge clk);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        e0 = cyc;
        tick_total = 15'(ticks);
        @(negedge clk);
        tick_total = '0;
    endtask

    task automatic expect_pulse(input int ticks, input int e0);
        ev_t e;
        if (ticks < 96) return;
        e.cyc  = e0 + 2;
        e.l    = (ticks >= 2880);
        e.s    = ~e.l;
        m_bits = {m_bits[3:0], e.l};
        m_len  = m_len + 3'd1;
        e.v    = (m_len == 3'd5);
        e.bits = m_bits;
        e.len  = m_len;
        if (e.v) begin
            m_bits = '0;
            m_len  = '0;
        end
        sb.push_back(e);
    endtask

    task automatic pulse(input int ticks);
        int e0;
        drive_pulse(ticks, e0);
        expect_pulse(ticks, e0);
    endtask

    task automatic pulse_then_idle(input int ticks);
        int e0;
        ev_t e;
        drive_pulse(ticks, e0);
        expect_pulse(ticks, e0);
        if (m_len != 0) begin
            e.cyc = e0 + GAP - 1; e.s = 0; e.l = 0; e.v = 1;
            e.bits = m_bits; e.len = m_len;
            sb.push_back(e);
            m_bits = '0;
            m_len  = '0;
        end
        repeat (GAP + 10) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL %s_drained got %0d pending events, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({pulse_short, pulse_long, symbol_valid, symbol_bits, symbol_len} !== 11'd0) begin
            failures++;
            $display("FAIL %s got s=%b l=%b v=%b bits=%b len=%0d, required all 0",
                     name, pulse_short, pulse_long, symbol_valid, symbol_bits, symbol_len);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(3);
        check_outputs_zero("reset_outputs");
        reset = 1'b1;
        idle(3);
        check_outputs_zero("after_release");
    endtask

    task automatic test_single_short();
        pulse_then_idle(500);
        check_drained("single_short");
    endtask

    task automatic test_short_long();
        pulse(500);
        idle(18);
        pulse_then_idle(4000);
        check_drained("short_long");
    endtask

    task automatic test_thresholds();
        pulse(95);
        idle(GAP + 10);
        check_drained("glitch_alone");
        pulse_then_idle(96);
        check_drained("short_min");
        pulse(2879);
        idle(18);
        pulse_then_idle(2880);
        check_drained("long_min");
    endtask

    task automatic test_full_buffer();
        pulse(15'h7FFF);
        idle(18);
        pulse(500);
        idle(18);
        pulse(4000);
        idle(18);
        pulse(2880);
        idle(18);
        pulse(2879);
        idle(GAP + 10);
        check_drained("full_buffer");
        checks++;
        if (symbol_bits !== 5'b10110 || symbol_len !== 3'd5) begin
            failures++;
            $display("FAIL full_hold got bits=%b len=%0d, required bits=10110 len=5",
                     symbol_bits, symbol_len);
        end
    endtask

    task automatic test_reset_mid_gap();
        pulse(500);
        idle(18);
        pulse(4000);
        idle(18);
        pulse(500);
        idle(30);
        check_drained("pre_reset");
        reset = 1'b0;
        m_bits = '0;
        m_len  = '0;
        idle(1);
        check_outputs_zero("mid_gap_reset");
        idle(2);
        reset = 1'b1;
        for (int i = 0; i < GAP + 10; i++) begin
            @(negedge clk);
            check_outputs_zero("post_reset_idle");
        end
        check_drained("reset_mid_gap");
    endtask

    task automatic test_start_high_release();
        int e0;
        reset = 1'b0;
        start = 1'b1;
        idle(2);
        reset = 1'b1;
        repeat (9) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        e0 = cyc;
        tick_total = 15'd10;
        @(negedge clk);
        tick_total = '0;
        expect_pulse(10, e0);
        idle(GAP + 10);
        check_drained("start_high_release");
        check_outputs_zero("start_high_outputs");
    endtask

    initial begin
        test_reset();
        test_single_short();
        test_short_long();
        test_thresholds();
        test_full_buffer();
        test_reset_mid_gap();
        test_start_high_release();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
